// File: rtl/checkbits_seq_monitor_pkg.sv
// checkbits_mon_pkg: shared FSM state and failure-cause encodings for the checkbits sequence monitor
package checkbits_mon_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_TIMEOUT  = 2'b01;
  localparam logic [1:0] FC_MISMATCH = 2'b10;
  localparam logic [1:0] FC_BADLEN   = 2'b11;
endpackage

// File: rtl/checkbits_seq_monitor_if.sv
// checkbits_seq_monitor_if: observed field, config/control inputs and result outputs of the monitor
interface checkbits_seq_monitor_if #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 1000000
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [WIDTH-1:0] obs;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [AW:0]      cfg_len;
  logic             strict;
  logic             start;
  logic             abort;
  logic             busy;
  logic             match_pulse;
  logic [AW-1:0]    match_idx;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_code;
  logic [WIDTH-1:0] fail_value;
  logic [TW-1:0]    elapsed;
  modport master (
    output obs, cfg_we, cfg_addr, cfg_data, cfg_len, strict, start, abort,
    input  busy, match_pulse, match_idx, pass, fail, fail_code, fail_value, elapsed
  );
  modport slave (
    input  obs, cfg_we, cfg_addr, cfg_data, cfg_len, strict, start, abort,
    output busy, match_pulse, match_idx, pass, fail, fail_code, fail_value, elapsed
  );
endinterface

// File: rtl/checkbits_seq_monitor_filter.sv
// obs_stable_filter: one event per value held for STABLE_CYC consecutive samples
module obs_stable_filter #(
  parameter int WIDTH      = 16,
  parameter int STABLE_CYC = 4
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] i_obs,
  output logic [WIDTH-1:0] o_stable_val,
  output logic             o_stable_evt
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  logic [WIDTH-1:0] r_obs_q;
  logic [CW-1:0]    r_cnt;
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_obs_q <= '0;
      r_cnt   <= '0;
    end else begin
      r_obs_q <= i_obs;
      r_cnt   <= (i_obs != r_obs_q) ? '0 : (r_cnt == CW'(STABLE_CYC)) ? r_cnt : r_cnt + 1'b1;
    end
  end
  // saturation above STABLE_CYC-1 keeps a long hold from re-firing
  assign o_stable_val = r_obs_q;
  assign o_stable_evt = r_cnt == CW'(STABLE_CYC - 1);
endmodule

// File: rtl/checkbits_seq_monitor.sv
// checkbits_seq_monitor: checks a debounced field steps through a programmed sequence within a cycle budget
module checkbits_seq_monitor
  import checkbits_mon_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic                    clock,
  input logic                    resetb,
  checkbits_seq_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t           r_state;
  logic [WIDTH-1:0] r_exp [DEPTH];
  logic [AW-1:0]    r_idx;
  logic [AW:0]      r_len;
  logic             r_strict;
  logic             r_busy;
  logic             r_match_pulse;
  logic [AW-1:0]    r_match_idx;
  logic             r_pass;
  logic             r_fail;
  logic [1:0]       r_fail_code;
  logic [WIDTH-1:0] r_fail_value;
  logic [TW-1:0]    r_elapsed;
  logic [WIDTH-1:0] w_val;
  logic             w_evt;
  logic             w_hit;
  logic             w_miss;
  logic             w_last;
  logic             w_win;
  logic             w_tmo;
  logic             w_done;
  logic             w_badlen;

  obs_stable_filter #(.WIDTH(WIDTH), .STABLE_CYC(STABLE_CYC)) u_filter (
    .clock        (clock),
    .resetb       (resetb),
    .i_obs        (bus.obs),
    .o_stable_val (w_val),
    .o_stable_evt (w_evt)
  );

  // lingering on the previous entry is tolerated so a slow edge never counts as out-of-sequence
  assign w_hit    = w_evt && w_val == r_exp[r_idx];
  assign w_miss   = w_evt && r_strict && r_idx != '0 && !w_hit && w_val != r_exp[r_idx - 1'b1];
  assign w_last   = r_len == (AW+1)'(r_idx) + 1'b1;
  assign w_win    = w_hit && w_last;
  assign w_tmo    = r_elapsed == TW'(TIMEOUT_CYC - 1);
  assign w_done   = w_win || w_miss || w_tmo;
  assign w_badlen = bus.cfg_len == '0 || bus.cfg_len > (AW+1)'(DEPTH);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state       <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) r_exp[i] <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_strict      <= 1'b0;
      r_busy        <= 1'b0;
      r_match_pulse <= 1'b0;
      r_match_idx   <= '0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_fail_code   <= FC_NONE;
      r_fail_value  <= '0;
      r_elapsed     <= '0;
    end else begin
      r_match_pulse <= 1'b0;
      if (bus.cfg_we && r_state != ST_RUN) r_exp[bus.cfg_addr] <= bus.cfg_data;
      if (bus.abort) begin
        r_state      <= ST_IDLE;
        r_busy       <= 1'b0;
        r_pass       <= 1'b0;
        r_fail       <= 1'b0;
        r_fail_code  <= FC_NONE;
        r_fail_value <= '0;
      end else if (r_state == ST_RUN) begin
        r_elapsed     <= (w_done || &r_elapsed) ? r_elapsed : r_elapsed + 1'b1;
        r_match_pulse <= w_hit;
        if (w_hit) r_match_idx <= r_idx;
        if (w_hit && !w_done) r_idx <= r_idx + 1'b1;
        // a final match beats a same-cycle timeout; a mismatch beats it too
        if (w_done) begin
          r_state      <= w_win ? ST_PASS : ST_FAIL;
          r_busy       <= 1'b0;
          r_pass       <= w_win;
          r_fail       <= !w_win;
          r_fail_code  <= w_win ? FC_NONE : w_miss ? FC_MISMATCH : FC_TIMEOUT;
          r_fail_value <= w_miss ? w_val : '0;
        end
      end else if (bus.start) begin
        r_state      <= w_badlen ? ST_FAIL : ST_RUN;
        r_busy       <= !w_badlen;
        r_idx        <= '0;
        r_len        <= bus.cfg_len;
        r_strict     <= bus.strict;
        r_elapsed    <= '0;
        r_pass       <= 1'b0;
        r_fail       <= w_badlen;
        r_fail_code  <= w_badlen ? FC_BADLEN : FC_NONE;
        r_fail_value <= '0;
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.match_pulse = r_match_pulse;
  assign bus.match_idx   = r_match_idx;
  assign bus.pass        = r_pass;
  assign bus.fail        = r_fail;
  assign bus.fail_code   = r_fail_code;
  assign bus.fail_value  = r_fail_value;
  assign bus.elapsed     = r_elapsed;
endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// tb_checkbits_seq_monitor: directed and random sequence runs against an event-level reference model
module tb_checkbits_seq_monitor;
  localparam int W = 16, D = 16, S = 4, T = 100;
  localparam logic [15:0] SEP = 16'hFFFF;
  logic clock = 1'b0;
  logic resetb = 1'b0;
  int n_chk = 0, n_fail = 0;
  int got_idx[$];
  logic [15:0] ex[$];
  logic [15:0] seg_v[$];
  int seg_h[$];

  always #5 clock = ~clock;

  checkbits_seq_monitor_if #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYC(T)) bus ();
  checkbits_seq_monitor #(.WIDTH(W), .DEPTH(D), .STABLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  always @(negedge clock) if (resetb && bus.match_pulse) got_idx.push_back(int'(bus.match_idx));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [15:0] v, input int h);
    seg_v.push_back(v);
    seg_h.push_back(h);
  endtask

  task automatic clear_segs();
    seg_v.delete();
    seg_h.delete();
  endtask

  // Segment i is first sampled k edges after the start edge; held S samples it yields an event k+S edges after start.
  task automatic run_seq(input string tag, input int len, input bit strict_m, input bit poke);
    int k = 0, idx = 0, n, e = 0;
    bit done = 0, m_pass = 0, m_fail = 0;
    logic [1:0] m_code = 2'b00;
    logic [15:0] m_val = '0;
    int m_el = 0;
    int m_idx[$];
    for (int i = 0; i < seg_v.size(); i++) begin
      n = k + S;
      if (!done && n <= T && (seg_h[i] >= S || i == seg_v.size() - 1)) begin
        if (seg_v[i] == ex[idx]) begin
          m_idx.push_back(idx);
          if (idx == len - 1) begin done = 1; m_pass = 1; m_el = n - 1; end
          else if (n == T) begin done = 1; m_fail = 1; m_code = 2'b01; m_el = n - 1; end
          else idx++;
        end else if (strict_m && idx > 0 && seg_v[i] != ex[idx-1]) begin
          done = 1; m_fail = 1; m_code = 2'b10; m_val = seg_v[i]; m_el = n - 1;
        end
      end
      k += seg_h[i];
    end
    if (!done) begin m_fail = 1; m_code = 2'b01; m_el = T - 1; end
    bus.obs = SEP;
    for (int i = 0; i < len; i++) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'(i); bus.cfg_data = ex[i];
      tick();
    end
    bus.cfg_we = 1'b0;
    repeat (S + 2) tick();
    got_idx.delete();
    bus.cfg_len = 5'(len);
    bus.strict = strict_m;
    bus.cfg_addr = 4'd1;
    bus.cfg_data = 16'hDEAD;
    for (int i = 0; i < seg_v.size(); i++) begin
      bus.obs = seg_v[i];
      for (int j = 0; j < seg_h[i]; j++) begin
        bus.start = (e == 0);
        bus.cfg_we = poke && e == 2;
        tick();
        e++;
      end
    end
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    for (int g = 0; g < T + 10 && bus.busy; g++) tick();
    tick();
    check({tag, ".busy"}, bus.busy, 0);
    check({tag, ".pass"}, bus.pass, m_pass);
    check({tag, ".fail"}, bus.fail, m_fail);
    check({tag, ".code"}, bus.fail_code, m_code);
    check({tag, ".value"}, bus.fail_value, m_val);
    check({tag, ".elapsed"}, bus.elapsed, m_el);
    check({tag, ".matches"}, got_idx.size(), m_idx.size());
    for (int i = 0; i < m_idx.size() && i < got_idx.size(); i++)
      check($sformatf("%s.idx%0d", tag, i), got_idx[i], m_idx[i]);
  endtask

  task automatic bad_len(input string tag, input int l);
    bus.cfg_len = 5'(l);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, ".fail"}, bus.fail, 1);
    check({tag, ".code"}, bus.fail_code, 2'b11);
    check({tag, ".busy"}, bus.busy, 0);
    check({tag, ".pass"}, bus.pass, 0);
  endtask

  task automatic random_run(input int t);
    int len, p = 0, r, nseg;
    logic [15:0] v, prev = SEP;
    len = $urandom_range(1, 4);
    ex.delete();
    for (int i = 0; i < len; i++) ex.push_back(16'($urandom_range(0, 32767)));
    clear_segs();
    nseg = $urandom_range(1, 8);
    for (int i = 0; i < nseg; i++) begin
      do begin
        r = $urandom_range(0, 9);
        v = r < 6 ? ex[p] : r < 8 ? ex[$urandom_range(0, len - 1)] : 16'h8000 | 16'($urandom_range(0, 32766));
      end while (v == prev);
      if (v == ex[p] && p < len - 1) p++;
      add(v, $urandom_range(2, 9));
      prev = v;
    end
    run_seq($sformatf("rnd%0d", t), len, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    bus.obs = '0; bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.cfg_len = '0; bus.strict = 0; bus.start = 0; bus.abort = 0;
    repeat (3) tick();
    check("rst.busy", bus.busy, 0);
    check("rst.match_pulse", bus.match_pulse, 0);
    check("rst.match_idx", bus.match_idx, 0);
    check("rst.pass", bus.pass, 0);
    check("rst.fail", bus.fail, 0);
    check("rst.code", bus.fail_code, 0);
    check("rst.value", bus.fail_value, 0);
    check("rst.elapsed", bus.elapsed, 0);
    @(negedge clock) resetb = 1'b1;
    tick();
    ex = '{16'hAB40, 16'h003E, 16'h0044, 16'hAB51};
    clear_segs(); add(16'hAB40, 10); add(16'h003E, 10); add(16'h0044, 10); add(16'hAB51, 10);
    run_seq("seq4", 4, 1'b0, 1'b1);
    ex = '{16'hAB40, 16'h0016, 16'h001C};
    clear_segs(); add(16'hAB40, 10); add(16'h0016, 10); add(16'h1234, 10);
    run_seq("strict_bad", 3, 1'b1, 1'b0);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    check("abort_fail.fail", bus.fail, 0);
    check("abort_fail.code", bus.fail_code, 0);
    check("abort_fail.value", bus.fail_value, 0);
    clear_segs(); add(16'hAB40, 10); add(16'h0016, 10); add(16'h1234, 10); add(16'h001C, 10);
    run_seq("lax", 3, 1'b0, 1'b0);
    bus.obs = 16'h1111; bus.cfg_len = 5'd3; bus.strict = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("abort_run.busy_before", bus.busy, 1);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    check("abort_run.busy", bus.busy, 0);
    check("abort_run.pass", bus.pass, 0);
    check("abort_run.fail", bus.fail, 0);
    check("abort_run.elapsed", bus.elapsed, 5);
    bus.start = 1'b1; bus.abort = 1'b1; tick(); bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_start.busy", bus.busy, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (3) tick();
    resetb = 1'b0;
    #1;
    check("rst_run.busy", bus.busy, 0);
    check("rst_run.fail", bus.fail, 0);
    check("rst_run.elapsed", bus.elapsed, 0);
    @(negedge clock) resetb = 1'b1;
    tick();
    ex = '{16'hAB40, 16'h0016};
    clear_segs(); add(16'hAB40, 5);
    run_seq("tmo", 2, 1'b0, 1'b0);
    clear_segs(); add(16'hAB40, 96); add(16'h0016, 10);
    run_seq("tmo_final_win", 2, 1'b0, 1'b0);
    ex = '{16'hAB40, 16'h0016, 16'h001C};
    run_seq("tmo_mid_match", 3, 1'b0, 1'b0);
    clear_segs(); add(16'hAB40, 40); add(16'h0016, 56); add(16'h1234, 10);
    run_seq("tmo_mismatch", 3, 1'b1, 1'b0);
    ex = '{16'hAB40, 16'h003E};
    clear_segs(); add(16'hAB40, 10); add(16'h003E, S - 1); add(16'h0050, 5);
    run_seq("glitch", 2, 1'b0, 1'b0);
    bad_len("len0", 0);
    bad_len("len17", 17);
    for (int t = 0; t < 25; t++) random_run(t);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
